// File: rtl/regfile_bank.sv
// ============================================================================
// Module   : regfile_bank
// Brief    : 32 x 32-bit register storage with one write port, a flat bank_out
//            bus and a clear FSM that zeroes one register per cycle.
//            Optional macro WRITE_BYPASS_EN forwards accepted write data onto
//            bank_out in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_wr_en,
  input  logic [ADDR_W-1:0]                  i_wr_addr,
  input  logic [DATA_W-1:0]                  i_wr_data,
  output logic                               o_wr_ready,
  input  logic                               i_clear_req,
  output logic                               o_clear_busy,
  output logic                               o_clear_done,
  output logic [(1<<ADDR_W)*DATA_W-1:0]      o_bank_out
);

  localparam int                c_NREGS    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(c_NREGS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_idx;
  logic                r_busy;
  logic                r_done;
  logic [DATA_W-1:0]   r_regs [c_NREGS];
  logic                w_wr_fire;

  assign o_wr_ready   = (r_state == S_IDLE);
  assign o_clear_busy = r_busy;
  assign o_clear_done = r_done;

  // Register 0 is never a write target, so it holds its reset value of zero.
  assign w_wr_fire = i_wr_en && o_wr_ready && (i_wr_addr != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < c_NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_wr_fire) begin
            r_regs[i_wr_addr] <= i_wr_data;
          end
          // A same-edge write lands first; the clear sweep zeroes it later.
          if (i_clear_req) begin
            r_state <= S_CLEAR;
            r_idx   <= ADDR_W'(1);
            r_busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_regs[r_idx] <= '0;
          r_idx         <= r_idx + 1'b1;
          if (r_idx == c_LAST_IDX) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < c_NREGS; gi++) begin : g_bank_out
`ifdef WRITE_BYPASS_EN
    assign o_bank_out[gi*DATA_W +: DATA_W] =
      (w_wr_fire && (i_wr_addr == ADDR_W'(gi))) ? i_wr_data : r_regs[gi];
`else
    assign o_bank_out[gi*DATA_W +: DATA_W] = r_regs[gi];
`endif
  end

endmodule

`default_nettype wire
